// File: rtl/tv80_blkseq_if.sv
// Memory request/acknowledge bus between the TV80 block-transfer sequencer
// and memory. A transfer completes at an edge where mem_req and mem_ack are
// both high; mem_rdata is valid together with mem_ack.
interface tv80_blkseq_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/tv80_blkseq.sv
// TV80 block-transfer sequencer: runs LDI/LDD/LDIR/LDDR as a self-timed
// micro-sequence over register-file port A and the memory req/ack bus.
// Define TV80_BLK_COMPARE_EN to add CPI/CPD/CPIR/CPDR (compare forms).
module tv80_blkseq (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,      // 0 = increment HL/DE, 1 = decrement
    input  logic          rpt,      // repeat form (xxIR/xxDR)
    input  logic          alt,      // alternate register set
    input  logic          cmp,      // compare form (CPx)
    input  logic [7:0]    acc,
    output logic          busy,
    output logic          done,
    output logic          pv_flag,
    output logic          z_flag,
    output logic [2:0]    reg_addr,
    output logic [7:0]    reg_dih,
    output logic [7:0]    reg_dil,
    output logic          reg_weh,
    output logic          reg_wel,
    output logic          reg_cen,
    input  logic [7:0]    reg_doh,
    input  logic [7:0]    reg_dol,
    tv80_blkseq_if.master mem
);

    typedef enum logic [3:0] {
        IDLE, LD_BC, LD_HL, LD_DE, MRD, MWR, WB_HL, WB_DE, WB_BC, DONE
    } state_t;

    // Low two bits of the register-file address for each pair.
    localparam logic [1:0] SEL_BC = 2'd0;
    localparam logic [1:0] SEL_DE = 2'd1;
    localparam logic [1:0] SEL_HL = 2'd2;

    state_t      state;
    logic        dir_q;
    logic        rpt_q;
    logic        alt_q;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [7:0]  data;

    logic [15:0] rd_pair;
    logic [15:0] hl_step;
    logic [15:0] de_step;
    logic [15:0] bc_dec;
    logic        xfer;
    logic        cmp_mode;
    logic        match;

    assign rd_pair = {reg_doh, reg_dol};
    assign hl_step = dir_q ? hl - 16'd1 : hl + 16'd1;
    assign de_step = dir_q ? de - 16'd1 : de + 16'd1;
    assign bc_dec  = bc - 16'd1;
    assign xfer    = mem.mem_req && mem.mem_ack;

`ifdef TV80_BLK_COMPARE_EN
    logic       cmp_q;
    logic [7:0] acc_q;

    // Capture the compare command qualifiers when a command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= 1'b0;
            acc_q <= 8'h00;
        end else if (state == IDLE && start) begin
            cmp_q <= cmp;
            acc_q <= acc;
        end
    end

    assign cmp_mode = cmp_q;
    assign match    = cmp_q && (data == acc_q);
`else
    logic unused_cmp;

    assign unused_cmp = ^{cmp, acc};
    assign cmp_mode   = 1'b0;
    assign match      = 1'b0;
`endif

    // Sequencer: advances the state and registers every output for the state being entered.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking only, so each register here sees the pre-edge values of the others.
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pv_flag       <= 1'b0;
            z_flag        <= 1'b0;
            reg_addr      <= 3'd0;
            reg_dih       <= 8'h00;
            reg_dil       <= 8'h00;
            reg_weh       <= 1'b0;
            reg_wel       <= 1'b0;
            reg_cen       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 8'h00;
            dir_q         <= 1'b0;
            rpt_q         <= 1'b0;
            alt_q         <= 1'b0;
            bc            <= 16'h0000;
            de            <= 16'h0000;
            hl            <= 16'h0000;
            data          <= 8'h00;
        end else begin
            done    <= 1'b0;
            reg_weh <= 1'b0;
            reg_wel <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q    <= dir;
                        rpt_q    <= rpt;
                        alt_q    <= alt;
                        busy     <= 1'b1;
                        reg_cen  <= 1'b1;
                        reg_addr <= {alt, SEL_BC};
                        state    <= LD_BC;
                    end
                end
                LD_BC: begin
                    bc       <= rd_pair;
                    reg_addr <= {alt_q, SEL_HL};
                    state    <= LD_HL;
                end
                LD_HL: begin
                    hl <= rd_pair;
                    if (cmp_mode) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= rd_pair;
                        state        <= MRD;
                    end else begin
                        reg_addr <= {alt_q, SEL_DE};
                        state    <= LD_DE;
                    end
                end
                LD_DE: begin
                    de           <= rd_pair;
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= hl;
                    state        <= MRD;
                end
                MRD: begin
                    if (xfer) begin
                        data <= mem.mem_rdata;
                        if (cmp_mode) begin
                            mem.mem_req          <= 1'b0;
                            hl                   <= hl_step;
                            reg_addr             <= {alt_q, SEL_HL};
                            {reg_dih, reg_dil}   <= hl_step;
                            reg_weh              <= 1'b1;
                            reg_wel              <= 1'b1;
                            state                <= WB_HL;
                        end else begin
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= de;
                            mem.mem_wdata <= mem.mem_rdata;
                            state         <= MWR;
                        end
                    end
                end
                MWR: begin
                    if (xfer) begin
                        mem.mem_req        <= 1'b0;
                        mem.mem_we         <= 1'b0;
                        hl                 <= hl_step;
                        reg_addr           <= {alt_q, SEL_HL};
                        {reg_dih, reg_dil} <= hl_step;
                        reg_weh            <= 1'b1;
                        reg_wel            <= 1'b1;
                        state              <= WB_HL;
                    end
                end
                WB_HL: begin
                    reg_weh <= 1'b1;
                    reg_wel <= 1'b1;
                    if (cmp_mode) begin
                        bc                 <= bc_dec;
                        reg_addr           <= {alt_q, SEL_BC};
                        {reg_dih, reg_dil} <= bc_dec;
                        state              <= WB_BC;
                    end else begin
                        de                 <= de_step;
                        reg_addr           <= {alt_q, SEL_DE};
                        {reg_dih, reg_dil} <= de_step;
                        state              <= WB_DE;
                    end
                end
                WB_DE: begin
                    bc                 <= bc_dec;
                    reg_addr           <= {alt_q, SEL_BC};
                    {reg_dih, reg_dil} <= bc_dec;
                    reg_weh            <= 1'b1;
                    reg_wel            <= 1'b1;
                    state              <= WB_BC;
                end
                WB_BC: begin
                    // bc already holds the decremented count here.
                    if (rpt_q && bc != 16'h0000 && !match) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= hl;
                        state        <= MRD;
                    end else begin
                        done    <= 1'b1;
                        pv_flag <= (bc != 16'h0000);
                        z_flag  <= match;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    reg_cen <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_blkseq.sv
// Self-checking bench for tv80_blkseq: a register-file and memory model around
// the DUT, a behavioural reference model that predicts each command's effects,
// and monitors that compare register writes, memory writes and completions.
module tb_tv80_blkseq;

`ifdef TV80_BLK_COMPARE_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       dir;
    logic       rpt;
    logic       alt;
    logic       cmp;
    logic [7:0] acc;
    logic       busy;
    logic       done;
    logic       pv_flag;
    logic       z_flag;
    logic [2:0] reg_addr;
    logic [7:0] reg_dih;
    logic [7:0] reg_dil;
    logic       reg_weh;
    logic       reg_wel;
    logic       reg_cen;
    logic [7:0] reg_doh;
    logic [7:0] reg_dol;

    tv80_blkseq_if mem_bus ();

    tv80_blkseq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dir      (dir),
        .rpt      (rpt),
        .alt      (alt),
        .cmp      (cmp),
        .acc      (acc),
        .busy     (busy),
        .done     (done),
        .pv_flag  (pv_flag),
        .z_flag   (z_flag),
        .reg_addr (reg_addr),
        .reg_dih  (reg_dih),
        .reg_dil  (reg_dil),
        .reg_weh  (reg_weh),
        .reg_wel  (reg_wel),
        .reg_cen  (reg_cen),
        .reg_doh  (reg_doh),
        .reg_dol  (reg_dol),
        .mem      (mem_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // ---------------- register file and memory models ----------------
    logic [15:0] rf [8];
    logic [7:0]  mem_arr [0:65535];
    int unsigned rd_wait;
    int unsigned wr_wait;
    int unsigned wcnt;

    assign reg_doh = rf[reg_addr][15:8];
    assign reg_dol = rf[reg_addr][7:0];

    always @(posedge clk) begin
        if (reg_cen && (reg_weh || reg_wel))
            rf[reg_addr] <= {reg_dih, reg_dil};
    end

    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
    assign mem_bus.mem_ack   = mem_bus.mem_req &&
                               (wcnt == (mem_bus.mem_we ? wr_wait : rd_wait));

    always @(posedge clk) begin
        if (reset) begin
            wcnt <= 0;
        end else if (mem_bus.mem_req) begin
            if (mem_bus.mem_ack) begin
                if (mem_bus.mem_we)
                    mem_arr[mem_bus.mem_addr] <= mem_bus.mem_wdata;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [2:0]  base;
        logic [15:0] bc;
        logic [15:0] de;
        logic [15:0] hl;
        logic        pv;
        logic        z;
        logic [31:0] cycles;
    } exp_t;

    exp_t        exp_q [$];
    logic [23:0] wq [$];     // {addr, data} of each expected memory write
    logic [18:0] rfq [$];    // {reg index, value} of each expected register write
    logic [15:0] ref_rf [8];
    logic [7:0]  ref_mem [0:65535];

    task automatic set_regs(input logic a, input logic [15:0] bc_v, de_v, hl_v);
        logic [2:0] b;
        b = a ? 3'd4 : 3'd0;
        rf[b] = bc_v;          ref_rf[b] = bc_v;
        rf[b + 3'd1] = de_v;   ref_rf[b + 3'd1] = de_v;
        rf[b + 3'd2] = hl_v;   ref_rf[b + 3'd2] = hl_v;
    endtask

    task automatic poke(input logic [15:0] addr, input logic [7:0] val);
        mem_arr[addr] = val;
        ref_mem[addr] = val;
    endtask

    // Z80 block-instruction semantics, one byte per loop pass.
    task automatic predict(input logic d, r, a, c, input logic [7:0] ac,
                           input int unsigned rw, ww, output int cycles);
        exp_t        e;
        logic [2:0]  base;
        logic [15:0] bc, de, hl;
        logic [7:0]  b;
        logic        ce, z, again;
        int          n;
        base = a ? 3'd4 : 3'd0;
        ce   = c && CMP_EN;
        bc   = ref_rf[base];
        de   = ref_rf[base + 3'd1];
        hl   = ref_rf[base + 3'd2];
        z    = 1'b0;
        n    = 0;
        do begin
            b = ref_mem[hl];
            if (ce) begin
                z = (b == ac);
            end else begin
                ref_mem[de] = b;
                wq.push_back({de, b});
            end
            hl = d ? hl - 16'd1 : hl + 16'd1;
            rfq.push_back({base + 3'd2, hl});
            if (!ce) begin
                de = d ? de - 16'd1 : de + 16'd1;
                rfq.push_back({base + 3'd1, de});
            end
            bc = bc - 16'd1;
            rfq.push_back({base, bc});
            n++;
            again = r && (bc != 16'h0000) && !z;
        end while (again);
        ref_rf[base]        = bc;
        ref_rf[base + 3'd1] = de;
        ref_rf[base + 3'd2] = hl;
        cycles = ce ? 3 + n * (3 + int'(rw)) : 4 + n * (5 + int'(rw) + int'(ww));
        e.base   = base;
        e.bc     = bc;
        e.de     = de;
        e.hl     = hl;
        e.pv     = (bc != 16'h0000);
        e.z      = z;
        e.cycles = cycles;
        exp_q.push_back(e);
    endtask

    // ---------------- monitors ----------------
    int          busy_cnt = 0;
    bit          pend = 1'b0;
    bit          stable = 1'b1;
    logic [15:0] p_addr;
    logic        p_we;
    logic [7:0]  p_wdata;

    // Completion monitor: compares final register pairs, flags and latency.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        else      busy_cnt = 0;
        if (done) begin
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("final_bc", rf[e.base], e.bc);
                check("final_de", rf[e.base + 3'd1], e.de);
                check("final_hl", rf[e.base + 3'd2], e.hl);
                check("pv_flag", pv_flag, e.pv);
                check("z_flag", z_flag, e.z);
                check("cycles", busy_cnt, e.cycles);
                check("busy_in_done", busy, 1);
                check("reg_cen_in_done", reg_cen, 1);
            end
        end
    end

    // Register-file write monitor.
    always @(negedge clk) begin
        logic [18:0] w;
        if (reg_weh || reg_wel) begin
            check("weh_eq_wel", reg_weh, reg_wel);
            check("rf_write_expected", rfq.size() != 0, 1);
            if (rfq.size() != 0) begin
                w = rfq.pop_front();
                check("rf_write_addr", reg_addr, w[18:16]);
                check("rf_write_data", {reg_dih, reg_dil}, w[15:0]);
            end
        end
    end

    // Memory bus monitor: handshake stability and write contents.
    always @(negedge clk) begin
        logic [23:0] w;
        if (reset || !mem_bus.mem_req) begin
            pend = 1'b0;
        end else begin
            if (!pend) begin
                stable  = 1'b1;
                p_addr  = mem_bus.mem_addr;
                p_we    = mem_bus.mem_we;
                p_wdata = mem_bus.mem_wdata;
            end else if (mem_bus.mem_addr != p_addr || mem_bus.mem_we != p_we ||
                         (p_we && mem_bus.mem_wdata != p_wdata)) begin
                stable = 1'b0;
            end
            if (mem_bus.mem_ack) begin
                check("handshake_stable", stable, 1);
                pend = 1'b0;
                if (mem_bus.mem_we) begin
                    check("mem_write_expected", wq.size() != 0, 1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        check("mem_write_addr", mem_bus.mem_addr, w[23:8]);
                        check("mem_write_data", mem_bus.mem_wdata, w[7:0]);
                    end
                end
            end else begin
                pend = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic d, r, a, c, input logic [7:0] ac,
                           input int unsigned rw, ww, input bit spurious);
        int budget;
        rd_wait = rw;
        wr_wait = ww;
        predict(d, r, a, c, ac, rw, ww, budget);
        budget += 20;
        @(negedge clk);
        dir = d; rpt = r; alt = a; cmp = c; acc = ac; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dir = ~d; rpt = ~r; alt = ~a; cmp = ~c; acc = ~ac;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < budget && busy; i++) begin
            start = spurious && (i % 3 == 1);
            @(negedge clk);
        end
        start = 1'b0;
        if (busy) begin
            check("cmd_timeout_busy", busy, 0);
            finish_run();
        end
    endtask

    initial begin
        #2000000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        logic [15:0] hl_v;
        logic        d, r, a, c;
        reset = 1'b1; start = 1'b0; dir = 1'b0; rpt = 1'b0; alt = 1'b0;
        cmp = 1'b0; acc = 8'h00; rd_wait = 0; wr_wait = 0;
        for (int i = 0; i < 65536; i++) poke(16'(i), 8'($urandom));
        for (int i = 0; i < 8; i++) begin
            rf[i] = 16'($urandom);
            ref_rf[i] = rf[i];
        end
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pv", pv_flag, 0);
        check("rst_z", z_flag, 0);
        check("rst_we", {reg_weh, reg_wel, reg_cen}, 0);
        check("rst_mem_ctl", {mem_bus.mem_req, mem_bus.mem_we}, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_data", {reg_dih, reg_dil}, 0);
        check("rst_mem_addr", mem_bus.mem_addr, 0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 0);
        reset = 1'b0;

        // LDI, zero wait.
        set_regs(1'b0, 16'h0003, 16'h2000, 16'h1000);
        poke(16'h1000, 8'h5A);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);

        // LDDR over three bytes.
        set_regs(1'b0, 16'h0003, 16'h2002, 16'h1002);
        poke(16'h1000, 8'h11); poke(16'h1001, 8'h22); poke(16'h1002, 8'h33);
        run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1'b1);

        // Address wrap on the alternate set.
        set_regs(1'b1, 16'h0001, 16'h0000, 16'hFFFF);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0);

        // Read wait states.
        set_regs(1'b0, 16'h0005, 16'h3000, 16'h1100);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 0, 1'b0);

        // BC = 0000 without repeat wraps to FFFF.
        set_regs(1'b0, 16'h0000, 16'h3100, 16'h1200);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 1'b0);

        // Reset while a memory write is stalled.
        set_regs(1'b0, 16'h0004, 16'h3200, 16'h1300);
        rd_wait = 0;
        wr_wait = 100000;
        @(negedge clk);
        dir = 1'b0; rpt = 1'b1; alt = 1'b0; cmp = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !(mem_bus.mem_req && mem_bus.mem_we); i++) @(negedge clk);
        check("stall_in_mwr", {mem_bus.mem_req, mem_bus.mem_we}, 2'b11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_req", mem_bus.mem_req, 0);
        check("rst_mid_we", {reg_weh, reg_wel}, 0);
        reset = 1'b0;
        wr_wait = 0;
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);

`ifdef TV80_BLK_COMPARE_EN
        // CPIR stopping on a match.
        set_regs(1'b0, 16'h0010, 16'h4000, 16'h1000);
        poke(16'h1000, 8'h11); poke(16'h1001, 8'h22); poke(16'h1002, 8'h33);
        run_cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 0, 0, 1'b0);
`endif

        // Randomized commands.
        for (int k = 0; k < 40; k++) begin
            d = 1'($urandom); r = 1'($urandom); a = 1'($urandom); c = 1'($urandom);
            hl_v = 16'($urandom);
            set_regs(a, r ? 16'($urandom_range(1, 5)) : 16'($urandom), 16'($urandom), hl_v);
            run_cmd(d, r, a, c, $urandom_range(0, 1) ? ref_mem[hl_v + 16'($urandom_range(0, 2))] : 8'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("wq_empty", wq.size(), 0);
        check("rfq_empty", rfq.size(), 0);
        finish_run();
    end

endmodule
